// File: rtl/vga_dbuf_framebuffer_if.sv
// rtl/vga_dbuf_framebuffer_if.sv - pixel write and page flip bus for vga_dbuf_framebuffer
interface vga_dbuf_framebuffer_if #(
  parameter int CW = 8
);
  logic [10:0]   x;
  logic [10:0]   y;
  logic [CW-1:0] r;
  logic [CW-1:0] g;
  logic [CW-1:0] b;
  logic          pixel_write;
  logic          swap_req;
  logic          swap_pending;
  logic          swap_done;

  modport master (
    output x, y, r, g, b, pixel_write, swap_req,
    input  swap_pending, swap_done
  );

  modport slave (
    input  x, y, r, g, b, pixel_write, swap_req,
    output swap_pending, swap_done
  );
endinterface

// File: rtl/vga_dbuf_framebuffer.sv
// rtl/vga_dbuf_framebuffer.sv - VGA timing plus page-flipped colour framebuffer
// FB_DOUBLE_BUFFER_EN selects two pages with tear-free flips; otherwise one page.
module vga_dbuf_framebuffer #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CW       = 8
) (
  input  logic                    clk50,
  input  logic                    reset,
  vga_dbuf_framebuffer_if.slave   wr,
  output logic [7:0]              VGA_R,
  output logic [7:0]              VGA_G,
  output logic [7:0]              VGA_B,
  output logic                    VGA_CLK,
  output logic                    VGA_HS,
  output logic                    VGA_VS,
  output logic                    VGA_BLANK_n,
  output logic                    VGA_SYNC_n
);
  localparam int HTOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VTOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW     = $clog2(2 * HTOTAL);
  localparam int VW     = $clog2(VTOTAL);
  localparam int PIX    = H_ACTIVE * V_ACTIVE;
`ifdef FB_DOUBLE_BUFFER_EN
  localparam int NPAGE  = 2;
`else
  localparam int NPAGE  = 1;
`endif
  localparam int DEPTH  = NPAGE * PIX;
  localparam int MW     = $clog2(DEPTH);

  localparam logic [HW-1:0] H_LAST   = HW'(2 * HTOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(VTOTAL - 1);
  localparam logic [31:0]   H_ACT    = 32'(H_ACTIVE);
  localparam logic [31:0]   V_ACT    = 32'(V_ACTIVE);
  localparam logic [31:0]   HS_START = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0]   HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0]   VS_START = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0]   VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [31:0]   PIX_U    = 32'(PIX);
  localparam logic          HS_LVL   = (HS_POL != 0);
  localparam logic          VS_LVL   = (VS_POL != 0);

  // Row base as a sum of shifted copies, one per set bit of the line width.
  function automatic logic [31:0] row_base(input logic [31:0] row);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 32; i++) begin
      if (H_ACT[i]) acc = acc + (row << i);
    end
    return acc;
  endfunction

  function automatic logic [7:0] expand(input logic [CW-1:0] v);
    logic [7:0] o;
    for (int i = 0; i < 8; i++) o[7-i] = v[CW-1-(i%CW)];
    return o;
  endfunction

  logic [HW-1:0]   hcount_q, hcount_d;
  logic [VW-1:0]   vcount_q, vcount_d;
  logic [7:0]      r_q, r_d, g_q, g_d, b_q, b_d;
  logic            blank_n_q, blank_n_d;
  logic            front_page_q, front_page_d;
  logic            pending_q, pending_d;

  logic [3*CW-1:0] mem [DEPTH];
  logic [3*CW-1:0] rd_word;
  logic [31:0]     col32, v32, x32, y32;
  logic [31:0]     wr_addr32, rd_addr32;
  logic [MW-1:0]   wr_idx, rd_idx;
  logic            active, flip_cycle, wr_ok, do_flip;

  always_comb begin
    col32      = 32'(hcount_q[HW-1:1]);
    v32        = 32'(vcount_q);
    x32        = 32'(wr.x);
    y32        = 32'(wr.y);
    active     = (col32 < H_ACT) && (v32 < V_ACT);
    flip_cycle = (v32 == V_ACT - 32'd1) && (hcount_q == H_LAST);
    wr_ok      = wr.pixel_write && (x32 < H_ACT) && (y32 < V_ACT);
    wr_addr32  = row_base(y32) + x32;
    rd_addr32  = active ? (row_base(v32) + col32) : 32'd0;
`ifdef FB_DOUBLE_BUFFER_EN
    // Writers always target the page that is not being scanned out.
    if (!front_page_q) wr_addr32 = wr_addr32 + PIX_U;
    if (front_page_q)  rd_addr32 = rd_addr32 + PIX_U;
    do_flip    = flip_cycle && (pending_q || wr.swap_req);
`else
    do_flip    = flip_cycle;
`endif
    wr_idx     = MW'(wr_addr32);
    rd_idx     = MW'(rd_addr32);
    rd_word    = mem[rd_idx];
  end

  always_ff @(posedge clk50) begin
    if (wr_ok) mem[wr_idx] <= {wr.r, wr.g, wr.b};
  end

  always_comb begin
    hcount_d     = (hcount_q == H_LAST) ? '0 : hcount_q + HW'(1);
    vcount_d     = vcount_q;
    if (hcount_q == H_LAST) vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + VW'(1);

    r_d          = r_q;
    g_d          = g_q;
    b_d          = b_q;
    blank_n_d    = blank_n_q;
    // Colour and blank are captured together on the second half of each pixel.
    if (hcount_q[0]) begin
      blank_n_d = active;
      r_d       = active ? expand(rd_word[3*CW-1 -: CW]) : 8'd0;
      g_d       = active ? expand(rd_word[2*CW-1 -: CW]) : 8'd0;
      b_d       = active ? expand(rd_word[CW-1 -: CW])   : 8'd0;
    end

    front_page_d = front_page_q;
    pending_d    = pending_q;
`ifdef FB_DOUBLE_BUFFER_EN
    if (do_flip) begin
      front_page_d = ~front_page_q;
      pending_d    = 1'b0;
    end else if (wr.swap_req) begin
      pending_d    = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      hcount_q     <= '0;
      vcount_q     <= '0;
      r_q          <= 8'd0;
      g_q          <= 8'd0;
      b_q          <= 8'd0;
      blank_n_q    <= 1'b0;
      front_page_q <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      hcount_q     <= hcount_d;
      vcount_q     <= vcount_d;
      r_q          <= r_d;
      g_q          <= g_d;
      b_q          <= b_d;
      blank_n_q    <= blank_n_d;
      front_page_q <= front_page_d;
      pending_q    <= pending_d;
    end
  end

`ifdef FB_DOUBLE_BUFFER_EN
  assign wr.swap_pending = pending_q;
`else
  logic unused_swap;
  assign unused_swap     = wr.swap_req ^ front_page_q ^ pending_q;
  assign wr.swap_pending = 1'b0;
`endif
  assign wr.swap_done  = do_flip;

  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign VGA_BLANK_n = blank_n_q;
  assign VGA_CLK     = hcount_q[0];
  assign VGA_SYNC_n  = 1'b1;
  assign VGA_HS      = (col32 >= HS_START && col32 < HS_END) ? HS_LVL : ~HS_LVL;
  assign VGA_VS      = (v32 >= VS_START && v32 < VS_END) ? VS_LVL : ~VS_LVL;
endmodule

// File: tb/tb_vga_dbuf_framebuffer.sv
// tb/tb_vga_dbuf_framebuffer.sv - directed bench on a 15x10-pixel-period frame
module tb_vga_dbuf_framebuffer;
  localparam int LINE  = 30;
  localparam int FRAME = 300;
`ifdef FB_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic clk50 = 1'b0;
  logic reset = 1'b1;
  always #10 clk50 = ~clk50;

  vga_dbuf_framebuffer_if #(.CW(8)) bus8();
  vga_dbuf_framebuffer_if #(.CW(4)) bus4();

  logic [7:0] r8, g8, b8, r4, g4, b4;
  logic vclk8, hs8, vs8, bln8, syn8;
  logic vclk4, hs4, vs4, bln4, syn4;

  vga_dbuf_framebuffer #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .CW(8)
  ) dut (
    .clk50(clk50), .reset(reset), .wr(bus8),
    .VGA_R(r8), .VGA_G(g8), .VGA_B(b8),
    .VGA_CLK(vclk8), .VGA_HS(hs8), .VGA_VS(vs8),
    .VGA_BLANK_n(bln8), .VGA_SYNC_n(syn8)
  );

  vga_dbuf_framebuffer #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .CW(4)
  ) dut4 (
    .clk50(clk50), .reset(reset), .wr(bus4),
    .VGA_R(r4), .VGA_G(g4), .VGA_B(b4),
    .VGA_CLK(vclk4), .VGA_HS(hs4), .VGA_VS(vs4),
    .VGA_BLANK_n(bln4), .VGA_SYNC_n(syn4)
  );

  int cyc;
  int n_checks;
  int n_pass;
  int done_cnt;
  int done_base;

  always @(negedge clk50) begin
    if (!reset && bus8.swap_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk50);
    #1;
    cyc++;
  endtask

  task automatic go(input int f, input int v, input int h);
    int target;
    target = f * FRAME + v * LINE + h;
    if (cyc > target) check("order", cyc, target);
    while (cyc < target) step();
  endtask

  task automatic wr8(input int x, input int y, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    bus8.x = 11'(x);
    bus8.y = 11'(y);
    bus8.r = r;
    bus8.g = g;
    bus8.b = b;
    bus8.pixel_write = 1'b1;
    step();
    bus8.pixel_write = 1'b0;
  endtask

  task automatic wr4(input int x, input int y, input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    bus4.x = 11'(x);
    bus4.y = 11'(y);
    bus4.r = r;
    bus4.g = g;
    bus4.b = b;
    bus4.pixel_write = 1'b1;
    step();
    bus4.pixel_write = 1'b0;
  endtask

  task automatic swap8();
    bus8.swap_req = 1'b1;
    step();
    bus8.swap_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_r"}, r8, 8'h00);
    check({tag, "_blank_n"}, bln8, 1'b0);
    check({tag, "_hs"}, hs8, 1'b1);
    check({tag, "_vs"}, vs8, 1'b1);
    check({tag, "_pending"}, bus8.swap_pending, 1'b0);
    check({tag, "_done"}, bus8.swap_done, 1'b0);
  endtask

  initial begin
    cyc = 0; n_checks = 0; n_pass = 0; done_cnt = 0; done_base = 0;
    bus8.x = '0; bus8.y = '0; bus8.r = '0; bus8.g = '0; bus8.b = '0;
    bus8.pixel_write = 1'b0; bus8.swap_req = 1'b0;
    bus4.x = '0; bus4.y = '0; bus4.r = '0; bus4.g = '0; bus4.b = '0;
    bus4.pixel_write = 1'b0; bus4.swap_req = 1'b1;

    step(); step();
    check_reset_outputs("rst");
    check("rst_sync_n", syn8, 1'b1);
    check("rst_vga_clk", vclk8, 1'b0);
    reset = 1'b0;
    cyc = 0;

    // Frame 0: seed the back page, request a flip, verify line timing.
    wr8(0, 0, 8'h12, 8'h34, 8'h56);
    wr8(0, 2, 8'h12, 8'h34, 8'h56);
    wr8(3, 2, 8'h01, 8'h02, 8'h03);
    wr8(4, 2, 8'h00, 8'h00, 8'h00);
    wr8(8, 1, 8'h77, 8'h77, 8'h77);
    swap8();
    check("f0_pending", bus8.swap_pending, DB);
    for (int h = 0; h < LINE; h++) begin
      go(0, 1, h);
      check($sformatf("hs_h%0d", h), hs8, (h >= 20 && h <= 25) ? 1'b0 : 1'b1);
    end
    go(0, 0 + 1, 29);
    go(0, 5, 29);
    check("f0_flip_done", bus8.swap_done, 1'b1);

    // Frame 1: draw into the new back page while the old one is shown.
    go(1, 0, 1);
    check("f1_done_cnt", done_cnt, 1);
    go(1, 0, 2);
    wr8(0, 6, 8'h77, 8'h77, 8'h77);
    wr8(3, 2, 8'hFF, 8'h00, 8'h80);
    go(1, 0, 10);
    swap8();
    check("f1_pending_a", bus8.swap_pending, DB);
    go(1, 0, 20);
    wr4(1, 1, 4'hA, 4'h5, 4'h0);
    go(1, 1, 0);
    swap8();
    check("f1_pending_b", bus8.swap_pending, DB);
    go(1, 2, 2);
    check("f1_px0_r", r8, 8'h12);
    go(1, 2, 8);
    check("f1_px3_r", r8, DB ? 8'h01 : 8'hFF);
    go(1, 2, 10);
    check("f1_px4_r", r8, 8'h00);
    go(1, 3, 0);
    swap8();
    check("f1_pending_c", bus8.swap_pending, DB);
    go(1, 5, 28);
    check("f1_pending_pre", bus8.swap_pending, DB);

    // Frame 2: the new pixel is on screen; flip requested on the flip cycle.
    go(2, 0, 0);
    check("f2_pending_clear", bus8.swap_pending, 1'b0);
    go(2, 0, 1);
    check("f2_done_cnt", done_cnt, 2);
    go(2, 1, 4);
    check("cw4_r", r4, 8'hAA);
    check("cw4_g", g4, 8'h55);
    check("cw4_b", b4, 8'h00);
    go(2, 2, 8);
    check("f2_px3_r", r8, 8'hFF);
    check("f2_px3_g", g8, 8'h00);
    check("f2_px3_b", b8, 8'h80);
    go(2, 5, 28);
    check("f2_pending_pre", bus8.swap_pending, 1'b0);
    go(2, 5, 29);
    bus8.swap_req = 1'b1;
    bus8.x = 11'd4; bus8.y = 11'd2;
    bus8.r = 8'hAA; bus8.g = 8'hBB; bus8.b = 8'hCC;
    bus8.pixel_write = 1'b1;
    #1;
    check("f2_flip_done", bus8.swap_done, 1'b1);
    step();
    bus8.swap_req = 1'b0;
    bus8.pixel_write = 1'b0;
    check("f2_pending_post", bus8.swap_pending, 1'b0);

    // Frame 3: page written on the flip cycle is now displayed.
    go(3, 0, 1);
    check("f3_done_cnt", done_cnt, 3);
    go(3, 0, 2);
    check("f3_px00_r", r8, 8'h12);
    go(3, 2, 8);
    check("f3_px3_r", r8, DB ? 8'h01 : 8'hFF);
    go(3, 2, 10);
    check("f3_px4_r", r8, 8'hAA);
    check("f3_px4_g", g8, 8'hBB);
    check("f3_px4_b", b8, 8'hCC);
    check("f3_blank_n_act", bln8, 1'b1);
    check("f3_vga_clk_lo", vclk8, 1'b0);
    go(3, 2, 11);
    check("f3_vga_clk_hi", vclk8, 1'b1);
    go(3, 2, 20);
    check("f3_blank_n_h", bln8, 1'b0);
    check("f3_blank_r", r8, 8'h00);
    go(3, 6, 2);
    check("f3_blank_n_v", bln8, 1'b0);

    for (int v = 0; v < 10; v++) begin
      go(4, v, 1);
      check($sformatf("vs_v%0d", v), vs8, (v == 7 || v == 8) ? 1'b0 : 1'b1);
    end

    // Frame 5: reset mid-line with a flip outstanding.
    go(5, 3, 0);
    swap8();
    check("f5_pending", bus8.swap_pending, DB);
    go(5, 4, 7);
    reset = 1'b1;
    #2;
    check_reset_outputs("mid_rst");
    step(); step();
    reset = 1'b0;
    cyc = 0;
    done_base = done_cnt;
    check("post_rst_pending", bus8.swap_pending, 1'b0);
    go(0, 2, 8);
    check("post_rst_page0", r8, 8'hFF);
    go(0, 5, 28);
    check("post_rst_no_done", done_cnt, done_base);
    go(0, 5, 29);
    check("post_rst_flip_done", bus8.swap_done, !DB);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
